mem_ctrl: RTL and testbench
===========================

# mem_ctrl

Memory controller that sits directly downstream of the instruction cache and the MEM stage and is the only block driving the byte-wide unified RAM. It arbitrates between instruction-fetch misses and MEM-stage loads/stores. It serialises each access into 1, 2 or 4 byte transfers and returns assembled little-endian words. It reports per-requester busy and done flags.

## Interface
- No parameters. Address width 18, RAM data width 8, word 32: fixed.
- clk_in  input  1  clock; all state on rising edge.
- rst_in  input  1  synchronous active-low reset.
- rdy_in  input  1  global ready; low = pause.
- ic_req_in  input  1  instruction-fetch request (held by ICache until done).
- ic_addr_in  input  18  fetch byte address.
- ic_busy_out  output  1  ICache access in progress.
- ic_inst_valid_out  output  1  one-cycle pulse, ic_inst_out valid.
- ic_inst_out  output  32  fetched instruction.
- mem_req_in  input  1  MEM access request (held until done).
- mem_we_in  input  1  1 = store, 0 = load.
- mem_len_in  input  2  0 = byte, 1 = half, 2 = word; 3 is treated as word.
- mem_addr_in  input  18  byte address.
- mem_wdata_in  input  32  store data; low bytes used.
- mem_busy_out  output  1  MEM access in progress.
- mem_done_out  output  1  one-cycle pulse, load data valid or store committed.
- mem_rdata_out  output  32  load data, zero-extended.
- ram_addr_out  output  18  RAM byte address.
- ram_dout_out  output  8  RAM write byte.
- ram_wr_out  output  1  RAM write enable.
- ram_din_in  input  8  RAM read byte; valid the cycle after its address is sampled.

## Operation
- States: IDLE, READ, WRITE. Registers: owner (IC/MEM), N (bytes), byte counter, 32-bit assembly buffer, restart flag.
- Requests are sampled only in IDLE.
  - MEM has priority when mem_req_in and ic_req_in are both high; the ICache retries.
  - Requests raised while busy are not queued. Requesters hold them.
- Byte k of a transfer goes to address (addr+k) mod 2^18 and data bits [8k+7:8k] (little-endian).
- READ:
  - Issue addresses addr..addr+N-1 on consecutive cycles.
  - Capture ram_din_in one cycle after each address.
  - After the last byte, register the assembled word to the owner's data output, pulse its valid/done, and return to IDLE.
  - Unused upper bytes are 0.
- WRITE:
  - Drive ram_addr_out, ram_dout_out and ram_wr_out=1 for byte k on cycle k, for N cycles.
  - Pulse mem_done_out after the last byte, then return to IDLE.
  - An ICache request never enters WRITE.
- Busy outputs: high from the accept edge through the completion edge. Only the owner's busy output is high.
- rdy_in low:
  - FSM, counter, buffer and outputs hold.
  - ram_wr_out is forced 0.
  - In READ, the byte whose address was issued before the stall is re-issued on resume. Data sampled during a stall is discarded.
- Reset (rst_in=0 at an edge), at any time including mid-transfer:
  - State goes to IDLE and all outputs and registers go to 0.
  - The in-flight access is aborted with no done pulse.
  - Bytes already written stay written.

## Timing
- Request sampled in IDLE at edge t. At that edge ram_addr_out←addr and busy←1.
- Read of N bytes:
  - byte k is captured at edge t+2+k;
  - data and valid/done are registered at edge t+1+N;
  - word fetch: ic_inst_valid_out is high in the cycle after edge t+5.
  - State is IDLE after edge t+1+N, so the next accept is at edge t+2+N at the earliest.
- Write of N bytes:
  - ram_wr_out is high in the cycles after edges t..t+N-1;
  - mem_done_out is registered at edge t+N;
  - next accept is at edge t+N+1.
- Each stall cycle adds 1 cycle to latency. A read stall adds 1 further cycle for the re-issue.
- Done/valid pulses are exactly one cycle wide. Data outputs hold their value until the next completion or reset.
- Reset values: all outputs 0, ram_addr_out=0, state IDLE.

## Test plan
- Reset, then ic_req_in with ic_addr_in=0x00010, RAM bytes 13,00,05,93 -> ic_inst_valid_out pulses 5 cycles after accept with ic_inst_out=0x93050013; ic_busy_out high 5 cycles.
- MEM store word 0xDEADBEEF at 0x00100 -> ram_wr_out high 4 cycles with bytes EF,BE,AD,DE at 0x100..0x103; mem_done_out at edge t+4. Follow with a half load from 0x102 -> mem_rdata_out=0x0000DEAD.
- ic_req_in and mem_req_in (byte load at 0x3FFFF) raised in the same cycle -> MEM served first; ICache is accepted 3 cycles after the MEM accept edge.
- Word read at 0x3FFFE -> addresses 0x3FFFE, 0x3FFFF, 0x00000, 0x00001 (wrap-around).
- rdy_in low for 3 cycles mid word-read (after byte 1 captured) -> no ram_wr_out; byte 2 re-issued; correct word delivered 4 cycles later than nominal.
- rst_in=0 during byte 2 of a word write -> outputs 0 next cycle; no mem_done_out; bytes 0–1 remain in RAM; a new request is accepted normally afterwards.

Source files
------------

// File: rtl/mem_ctrl.sv
// mem_ctrl: arbitrates ICache fetches and MEM loads/stores onto one byte-wide RAM (clk_in/rst_in/rdy_in, ic_* fetch port, mem_* load/store port, ram_* RAM port)
module mem_ctrl (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        rdy_in,
  input  logic        ic_req_in,
  input  logic [17:0] ic_addr_in,
  output logic        ic_busy_out,
  output logic        ic_inst_valid_out,
  output logic [31:0] ic_inst_out,
  input  logic        mem_req_in,
  input  logic        mem_we_in,
  input  logic [1:0]  mem_len_in,
  input  logic [17:0] mem_addr_in,
  input  logic [31:0] mem_wdata_in,
  output logic        mem_busy_out,
  output logic        mem_done_out,
  output logic [31:0] mem_rdata_out,
  output logic [17:0] ram_addr_out,
  output logic [7:0]  ram_dout_out,
  output logic        ram_wr_out,
  input  logic [7:0]  ram_din_in
);
  typedef enum logic [1:0] {IDLE, READ, WRITE} state_t;
  state_t      state_q, state_d;
  logic        own_mem_q, own_mem_d;
  logic [2:0]  n_q, n_d, nxt_q, nxt_d, cnt_q, cnt_d;
  logic [1:0]  tag_q, tag_d, bus_tag_q, bus_tag_d, redo_tag_q, redo_tag_d;
  logic        vld_q, vld_d, redo_q, redo_d;
  logic [17:0] base_q, base_d, addr_q, addr_d;
  logic [31:0] word_q, word_d, wdata_q, wdata_d, inst_q, inst_d, rdata_q, rdata_d, cap;
  logic [7:0]  dout_q, dout_d;
  logic        wr_q, wr_d, ic_busy_q, ic_busy_d, mem_busy_q, mem_busy_d;
  logic        ic_valid_q, ic_valid_d, mem_done_q, mem_done_d, store;
  assign ic_busy_out       = ic_busy_q;
  assign ic_inst_valid_out = ic_valid_q;
  assign ic_inst_out       = inst_q;
  assign mem_busy_out      = mem_busy_q;
  assign mem_done_out      = mem_done_q;
  assign mem_rdata_out     = rdata_q;
  assign ram_addr_out      = addr_q;
  assign ram_dout_out      = dout_q;
  assign ram_wr_out        = wr_q & rdy_in;
  always_comb begin
    state_d    = state_q;
    own_mem_d  = own_mem_q;
    n_d        = n_q;
    nxt_d      = nxt_q;
    cnt_d      = cnt_q;
    tag_d      = tag_q;
    bus_tag_d  = bus_tag_q;
    redo_tag_d = redo_tag_q;
    vld_d      = vld_q;
    redo_d     = redo_q;
    base_d     = base_q;
    addr_d     = addr_q;
    word_d     = word_q;
    wdata_d    = wdata_q;
    inst_d     = inst_q;
    rdata_d    = rdata_q;
    dout_d     = dout_q;
    wr_d       = wr_q;
    ic_busy_d  = ic_busy_q;
    mem_busy_d = mem_busy_q;
    ic_valid_d = 1'b0;
    mem_done_d = 1'b0;
    store      = mem_req_in & mem_we_in;
    cap        = word_q;
    cap[8*tag_q +: 8] = ram_din_in;
    if (!rdy_in) begin
      if (state_q == READ && vld_q) begin
        vld_d      = 1'b0;
        redo_d     = 1'b1;
        redo_tag_d = tag_q;
      end
    end else if (state_q == IDLE) begin
      if (mem_req_in || ic_req_in) begin
        state_d    = store ? WRITE : READ;
        own_mem_d  = mem_req_in;
        n_d        = (!mem_req_in || mem_len_in[1]) ? 3'd4 : mem_len_in[0] ? 3'd2 : 3'd1;
        base_d     = mem_req_in ? mem_addr_in : ic_addr_in;
        addr_d     = mem_req_in ? mem_addr_in : ic_addr_in;
        wdata_d    = mem_wdata_in;
        dout_d     = mem_wdata_in[7:0];
        wr_d       = store;
        nxt_d      = 3'd1;
        cnt_d      = 3'd0;
        word_d     = 32'd0;
        vld_d      = 1'b0;
        redo_d     = 1'b0;
        bus_tag_d  = 2'd0;
        ic_busy_d  = !mem_req_in;
        mem_busy_d = mem_req_in;
      end
    end else if (state_q == READ) begin
      if (vld_q && cnt_q + 3'd1 == n_q) begin
        state_d    = IDLE;
        ic_busy_d  = 1'b0;
        mem_busy_d = 1'b0;
        rdata_d    = own_mem_q ? cap : rdata_q;
        inst_d     = own_mem_q ? inst_q : cap;
        mem_done_d = own_mem_q;
        ic_valid_d = !own_mem_q;
      end else begin
        word_d = vld_q ? cap : word_q;
        cnt_d  = cnt_q + {2'b0, vld_q};
        vld_d  = 1'b1;
        tag_d  = bus_tag_q;
        if (redo_q) begin
          redo_d    = 1'b0;
          bus_tag_d = redo_tag_q;
          addr_d    = base_q + 18'(redo_tag_q);
        end else if (nxt_q != n_q) begin
          bus_tag_d = nxt_q[1:0];
          addr_d    = base_q + 18'(nxt_q);
          nxt_d     = nxt_q + 3'd1;
        end
      end
    end else begin
      if (nxt_q == n_q) begin
        state_d    = IDLE;
        wr_d       = 1'b0;
        mem_busy_d = 1'b0;
        mem_done_d = 1'b1;
      end else begin
        addr_d = base_q + 18'(nxt_q);
        dout_d = wdata_q[8*nxt_q[1:0] +: 8];
        nxt_d  = nxt_q + 3'd1;
      end
    end
  end
  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      state_q    <= IDLE;
      own_mem_q  <= 1'b0;
      n_q        <= 3'd0;
      nxt_q      <= 3'd0;
      cnt_q      <= 3'd0;
      tag_q      <= 2'd0;
      bus_tag_q  <= 2'd0;
      redo_tag_q <= 2'd0;
      vld_q      <= 1'b0;
      redo_q     <= 1'b0;
      base_q     <= 18'd0;
      addr_q     <= 18'd0;
      word_q     <= 32'd0;
      wdata_q    <= 32'd0;
      inst_q     <= 32'd0;
      rdata_q    <= 32'd0;
      dout_q     <= 8'd0;
      wr_q       <= 1'b0;
      ic_busy_q  <= 1'b0;
      mem_busy_q <= 1'b0;
      ic_valid_q <= 1'b0;
      mem_done_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      own_mem_q  <= own_mem_d;
      n_q        <= n_d;
      nxt_q      <= nxt_d;
      cnt_q      <= cnt_d;
      tag_q      <= tag_d;
      bus_tag_q  <= bus_tag_d;
      redo_tag_q <= redo_tag_d;
      vld_q      <= vld_d;
      redo_q     <= redo_d;
      base_q     <= base_d;
      addr_q     <= addr_d;
      word_q     <= word_d;
      wdata_q    <= wdata_d;
      inst_q     <= inst_d;
      rdata_q    <= rdata_d;
      dout_q     <= dout_d;
      wr_q       <= wr_d;
      ic_busy_q  <= ic_busy_d;
      mem_busy_q <= mem_busy_d;
      ic_valid_q <= ic_valid_d;
      mem_done_q <= mem_done_d;
    end
  end
endmodule

// File: tb/tb_mem_ctrl.sv
// tb_mem_ctrl: directed checks of mem_ctrl against a byte-wide synchronous RAM model
module tb_mem_ctrl;
  logic        clk_in = 1'b0, rst_in = 1'b0, rdy_in = 1'b1;
  logic        ic_req_in = 1'b0, mem_req_in = 1'b0, mem_we_in = 1'b0;
  logic [17:0] ic_addr_in = '0, mem_addr_in = '0;
  logic [1:0]  mem_len_in = '0;
  logic [31:0] mem_wdata_in = '0;
  logic [7:0]  ram_din_in = '0;
  logic        ic_busy_out, ic_inst_valid_out, mem_busy_out, mem_done_out, ram_wr_out;
  logic [31:0] ic_inst_out, mem_rdata_out;
  logic [17:0] ram_addr_out;
  logic [7:0]  ram_dout_out;
  logic [7:0]  ram [0:262143];
  logic [25:0] wlog[$];
  logic [17:0] alog[$];
  int checks = 0, errors = 0, k = 0;
  mem_ctrl dut (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in),
    .ic_req_in(ic_req_in), .ic_addr_in(ic_addr_in), .ic_busy_out(ic_busy_out),
    .ic_inst_valid_out(ic_inst_valid_out), .ic_inst_out(ic_inst_out),
    .mem_req_in(mem_req_in), .mem_we_in(mem_we_in), .mem_len_in(mem_len_in),
    .mem_addr_in(mem_addr_in), .mem_wdata_in(mem_wdata_in), .mem_busy_out(mem_busy_out),
    .mem_done_out(mem_done_out), .mem_rdata_out(mem_rdata_out),
    .ram_addr_out(ram_addr_out), .ram_dout_out(ram_dout_out), .ram_wr_out(ram_wr_out),
    .ram_din_in(ram_din_in)
  );
  always #5 clk_in = ~clk_in;
  always @(posedge clk_in) begin
    if (ram_wr_out) begin
      ram[ram_addr_out] <= ram_dout_out;
      wlog.push_back({ram_addr_out, ram_dout_out});
    end
    ram_din_in <= ram[ram_addr_out];
  end
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(negedge clk_in);
    k++;
  endtask
  task automatic req_mem(input logic we, input logic [1:0] len, input logic [17:0] a, input logic [31:0] d);
    mem_req_in = 1'b1; mem_we_in = we; mem_len_in = len; mem_addr_in = a; mem_wdata_in = d;
    k = -1; wlog.delete(); alog.delete();
  endtask
  task automatic req_ic(input logic [17:0] a);
    ic_req_in = 1'b1; ic_addr_in = a;
    k = -1; wlog.delete(); alog.delete();
  endtask
  task automatic wait_pulse(input bit ic, output int at, output int busy);
    at = -1;
    busy = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      alog.push_back(ram_addr_out);
      if (ic ? ic_busy_out : mem_busy_out) busy++;
      if (ic ? ic_inst_valid_out : mem_done_out) begin
        at = k;
        if (ic) ic_req_in = 1'b0; else mem_req_in = 1'b0;
        break;
      end
    end
  endtask
  initial begin
    #100000;
    $display("FAIL timeout k=%0d", k);
    $fatal(1);
  end
  initial begin
    int at, b, acc, cnt;
    logic [31:0] d;
    logic [17:0] wexp [4];
    ram[18'h00010] = 8'h13; ram[18'h00011] = 8'h00; ram[18'h00012] = 8'h05; ram[18'h00013] = 8'h93;
    ram[18'h3FFFE] = 8'h11; ram[18'h3FFFF] = 8'h22; ram[18'h00000] = 8'h33; ram[18'h00001] = 8'h44;
    ram[18'h00200] = 8'hA1; ram[18'h00201] = 8'hB2; ram[18'h00202] = 8'hC3; ram[18'h00203] = 8'hD4;
    ram[18'h00403] = 8'h77;
    repeat (3) @(negedge clk_in);
    chk("rst_addr", 32'(ram_addr_out), 32'h0);
    chk("rst_wr", 32'(ram_wr_out), 32'h0);
    chk("rst_dout", 32'(ram_dout_out), 32'h0);
    chk("rst_flags", 32'({ic_busy_out, ic_inst_valid_out, mem_busy_out, mem_done_out}), 32'h0);
    chk("rst_inst", ic_inst_out, 32'h0);
    chk("rst_rdata", mem_rdata_out, 32'h0);
    rst_in = 1'b1;
    @(negedge clk_in);
    req_ic(18'h00010);
    wait_pulse(1'b1, at, b);
    chk("ic_at", 32'(at), 32'd5);
    chk("ic_busy_cycles", 32'(b), 32'd5);
    chk("ic_inst", ic_inst_out, 32'h93050013);
    chk("ic_busy_end", 32'(ic_busy_out), 32'h0);
    tick();
    chk("ic_pulse_width", 32'(ic_inst_valid_out), 32'h0);
    chk("ic_inst_hold", ic_inst_out, 32'h93050013);
    d = 32'hDEADBEEF;
    req_mem(1'b1, 2'd2, 18'h00100, d);
    wait_pulse(1'b0, at, b);
    chk("st_at", 32'(at), 32'd4);
    chk("st_nwr", 32'(wlog.size()), 32'd4);
    for (int i = 0; i < 4 && i < wlog.size(); i++)
      chk("st_byte", 32'(wlog[i]), {6'b0, 18'(18'h100 + i), d[8*i +: 8]});
    req_mem(1'b0, 2'd1, 18'h00102, 32'h0);
    wait_pulse(1'b0, at, b);
    chk("ldh_at", 32'(at), 32'd3);
    chk("ldh_data", mem_rdata_out, 32'h0000DEAD);
    req_mem(1'b0, 2'd0, 18'h3FFFF, 32'h0);
    ic_req_in = 1'b1; ic_addr_in = 18'h00010;
    wait_pulse(1'b0, at, b);
    chk("pri_mem_at", 32'(at), 32'd2);
    chk("pri_mem_data", mem_rdata_out, 32'h00000022);
    acc = -1;
    if (ic_busy_out) acc = k;
    for (int i = 0; i < 10 && acc < 0; i++) begin
      tick();
      if (ic_busy_out) acc = k;
    end
    chk("pri_ic_accept", 32'(acc), 32'd3);
    wait_pulse(1'b1, at, b);
    chk("pri_ic_at", 32'(at), 32'd8);
    chk("pri_ic_inst", ic_inst_out, 32'h93050013);
    req_mem(1'b0, 2'd2, 18'h3FFFE, 32'h0);
    wait_pulse(1'b0, at, b);
    chk("wrap_at", 32'(at), 32'd5);
    wexp = '{18'h3FFFE, 18'h3FFFF, 18'h00000, 18'h00001};
    for (int i = 0; i < 4 && i < alog.size(); i++)
      chk("wrap_addr", 32'(alog[i]), 32'(wexp[i]));
    chk("wrap_data", mem_rdata_out, 32'h44332211);
    req_mem(1'b0, 2'd2, 18'h00200, 32'h0);
    repeat (4) tick();
    rdy_in = 1'b0;
    tick();
    chk("stall_addr_hold", 32'(ram_addr_out), 32'h203);
    chk("stall_busy", 32'(mem_busy_out), 32'h1);
    tick();
    tick();
    rdy_in = 1'b1;
    tick();
    chk("stall_reissue", 32'(ram_addr_out), 32'h202);
    wait_pulse(1'b0, at, b);
    chk("stall_at", 32'(at), 32'd9);
    chk("stall_data", mem_rdata_out, 32'hD4C3B2A1);
    chk("stall_nwr", 32'(wlog.size()), 32'd0);
    req_mem(1'b1, 2'd1, 18'h00300, 32'h00001234);
    tick();
    rdy_in = 1'b0;
    #1;
    chk("wr_gated", 32'(ram_wr_out), 32'h0);
    tick();
    rdy_in = 1'b1;
    wait_pulse(1'b0, at, b);
    chk("wstall_at", 32'(at), 32'd3);
    chk("wstall_nwr", 32'(wlog.size()), 32'd2);
    if (wlog.size() == 2) begin
      chk("wstall_b0", 32'(wlog[0]), {6'b0, 18'h00300, 8'h34});
      chk("wstall_b1", 32'(wlog[1]), {6'b0, 18'h00301, 8'h12});
    end
    req_mem(1'b1, 2'd2, 18'h00400, 32'hCAFEF00D);
    repeat (3) tick();
    chk("rst_mid_addr", 32'(ram_addr_out), 32'h402);
    rst_in = 1'b0;
    mem_req_in = 1'b0;
    tick();
    chk("rstw_wr", 32'(ram_wr_out), 32'h0);
    chk("rstw_addr", 32'(ram_addr_out), 32'h0);
    chk("rstw_busy", 32'(mem_busy_out), 32'h0);
    chk("rstw_rdata", mem_rdata_out, 32'h0);
    rst_in = 1'b1;
    cnt = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (mem_done_out) cnt++;
    end
    chk("rstw_nodone", 32'(cnt), 32'd0);
    chk("rstw_ram0", 32'(ram[18'h00400]), 32'h0D);
    chk("rstw_ram1", 32'(ram[18'h00401]), 32'hF0);
    chk("rstw_ram3", 32'(ram[18'h00403]), 32'h77);
    req_ic(18'h00010);
    wait_pulse(1'b1, at, b);
    chk("post_rst_at", 32'(at), 32'd5);
    chk("post_rst_inst", ic_inst_out, 32'h93050013);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
